// File: rtl/padded_window_addr_gen.sv
// 3x3 sliding-window read address generator over the padded IFM buffer, gated by committed rows.
// Outputs are registered; the first read comes 2 cycles after start, and reads hold while rd_ready is low.
module padded_window_addr_gen #(
  parameter int PE     = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        IFM_C,
  input  logic [7:0]        IFM_W,
  input  logic              padding,
  input  logic              stride,
  input  logic              line_ready,
  input  logic              rd_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        tap_idx,
  output logic              last_tap,
  output logic              last_pixel,
  output logic              busy,
  output logic              done
);
  localparam int PE_SH = $clog2(PE);

  typedef enum logic [1:0] {IDLE, WAIT_ROWS, ISSUE, DONE} state_t;

  state_t state_q, state_d;

  logic [8:0]        wp_q, wp_d, ho_m1_q, ho_m1_d;
  logic [7:0]        cw_max_q, cw_max_d;
  logic              cfg_ok_q, cfg_ok_d, stride_q, stride_d;
  logic [ADDR_W-1:0] col_q, col_d, row_q, row_d, col_s_q, col_s_d, row_s_q, row_s_d;

  logic [8:0]        oy_q, oy_d, ox_q, ox_d;
  logic [7:0]        cw_q, cw_d;
  logic [1:0]        ky_q, ky_d, kx_q, kx_d;
  logic [9:0]        need_q, need_d;
  logic [8:0]        rows_q, rows_d;
  logic [ADDR_W-1:0] rowpix_q, rowpix_d, pix_q, pix_d, cwb_q, cwb_d, rowtap_q, rowtap_d;

  logic              rd_en_q, rd_en_d, last_tap_q, last_tap_d, last_pixel_q, last_pixel_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]        tap_q, tap_d;

  logic [8:0]        wp_calc, ho_m1_calc;
  logic [7:0]        cw_calc;
  logic [16:0]       prod_calc;
  logic [ADDR_W-1:0] col_calc, row_calc;

  // Row step is precomputed once per frame so the walk itself only adds.
  always_comb begin
    wp_calc    = {1'b0, IFM_W} + {7'd0, padding, 1'b0};
    cw_calc    = 8'(IFM_C >> PE_SH);
    ho_m1_calc = (wp_calc - 9'd3) >> stride;
    prod_calc  = 17'(cw_calc) * 17'(wp_calc);
    col_calc   = ADDR_W'(cw_calc) << 2;
    row_calc   = ADDR_W'(prod_calc) << 2;
  end

  always_comb begin
    state_d      = state_q;
    wp_d         = wp_q;
    ho_m1_d      = ho_m1_q;
    cw_max_d     = cw_max_q;
    cfg_ok_d     = cfg_ok_q;
    stride_d     = stride_q;
    col_d        = col_q;
    row_d        = row_q;
    col_s_d      = col_s_q;
    row_s_d      = row_s_q;
    oy_d         = oy_q;
    ox_d         = ox_q;
    cw_d         = cw_q;
    ky_d         = ky_q;
    kx_d         = kx_q;
    need_d       = need_q;
    rows_d       = rows_q;
    rowpix_d     = rowpix_q;
    pix_d        = pix_q;
    cwb_d        = cwb_q;
    rowtap_d     = rowtap_q;
    rd_en_d      = rd_en_q;
    rd_addr_d    = rd_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    if (state_q != IDLE && line_ready && rows_q < wp_q) begin
      rows_d = rows_q + 9'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WAIT_ROWS;
          busy_d    = 1'b1;
          wp_d      = wp_calc;
          ho_m1_d   = ho_m1_calc;
          cw_max_d  = cw_calc - 8'd1;
          cfg_ok_d  = (cw_calc != 8'd0) && (wp_calc >= 9'd3);
          stride_d  = stride;
          col_d     = col_calc;
          row_d     = row_calc;
          col_s_d   = col_calc << stride;
          row_s_d   = row_calc << stride;
          oy_d      = '0;
          ox_d      = '0;
          cw_d      = '0;
          ky_d      = '0;
          kx_d      = '0;
          need_d    = 10'd3;
          rows_d    = {8'd0, line_ready};
          rowpix_d  = base_addr;
          pix_d     = base_addr;
          cwb_d     = base_addr;
          rowtap_d  = base_addr;
          rd_addr_d = base_addr;
        end
      end
      WAIT_ROWS: begin
        if (!cfg_ok_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if ({1'b0, rows_q} >= need_q) begin
          state_d = ISSUE;
          rd_en_d = 1'b1;
        end
      end
      ISSUE: begin
        if (rd_ready) begin
          if (kx_q != 2'd2) begin
            kx_d      = kx_q + 2'd1;
            rd_addr_d = rd_addr_q + col_q;
          end else if (ky_q != 2'd2) begin
            kx_d      = 2'd0;
            ky_d      = ky_q + 2'd1;
            rowtap_d  = rowtap_q + row_q;
            rd_addr_d = rowtap_d;
          end else if (cw_q != cw_max_q) begin
            kx_d      = 2'd0;
            ky_d      = 2'd0;
            cw_d      = cw_q + 8'd1;
            cwb_d     = cwb_q + ADDR_W'(4);
            rowtap_d  = cwb_d;
            rd_addr_d = cwb_d;
          end else if (ox_q != ho_m1_q) begin
            kx_d      = 2'd0;
            ky_d      = 2'd0;
            cw_d      = 8'd0;
            ox_d      = ox_q + 9'd1;
            pix_d     = pix_q + col_s_q;
            cwb_d     = pix_d;
            rowtap_d  = pix_d;
            rd_addr_d = pix_d;
          end else if (oy_q != ho_m1_q) begin
            // New output row: may need more committed rows before continuing.
            kx_d      = 2'd0;
            ky_d      = 2'd0;
            cw_d      = 8'd0;
            ox_d      = 9'd0;
            oy_d      = oy_q + 9'd1;
            need_d    = need_q + (stride_q ? 10'd2 : 10'd1);
            rowpix_d  = rowpix_q + row_s_q;
            pix_d     = rowpix_d;
            cwb_d     = rowpix_d;
            rowtap_d  = rowpix_d;
            rd_addr_d = rowpix_d;
            state_d   = WAIT_ROWS;
            rd_en_d   = 1'b0;
          end else begin
            state_d = DONE;
            rd_en_d = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tap_d        = rd_en_d ? (4'(ky_d) * 4'd3 + 4'(kx_d)) : 4'd0;
    last_tap_d   = rd_en_d && ky_d == 2'd2 && kx_d == 2'd2 && cw_d == cw_max_d;
    last_pixel_d = last_tap_d && ox_d == ho_m1_d && oy_d == ho_m1_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wp_q         <= '0;
      ho_m1_q      <= '0;
      cw_max_q     <= '0;
      cfg_ok_q     <= 1'b0;
      stride_q     <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      col_s_q      <= '0;
      row_s_q      <= '0;
      oy_q         <= '0;
      ox_q         <= '0;
      cw_q         <= '0;
      ky_q         <= '0;
      kx_q         <= '0;
      need_q       <= '0;
      rows_q       <= '0;
      rowpix_q     <= '0;
      pix_q        <= '0;
      cwb_q        <= '0;
      rowtap_q     <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      tap_q        <= '0;
      last_tap_q   <= 1'b0;
      last_pixel_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      ho_m1_q      <= ho_m1_d;
      cw_max_q     <= cw_max_d;
      cfg_ok_q     <= cfg_ok_d;
      stride_q     <= stride_d;
      col_q        <= col_d;
      row_q        <= row_d;
      col_s_q      <= col_s_d;
      row_s_q      <= row_s_d;
      oy_q         <= oy_d;
      ox_q         <= ox_d;
      cw_q         <= cw_d;
      ky_q         <= ky_d;
      kx_q         <= kx_d;
      need_q       <= need_d;
      rows_q       <= rows_d;
      rowpix_q     <= rowpix_d;
      pix_q        <= pix_d;
      cwb_q        <= cwb_d;
      rowtap_q     <= rowtap_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      tap_q        <= tap_d;
      last_tap_q   <= last_tap_d;
      last_pixel_q <= last_pixel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign tap_idx    = tap_q;
  assign last_tap   = last_tap_q;
  assign last_pixel = last_pixel_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_padded_window_addr_gen.sv
// Bench for padded_window_addr_gen: table of configs with hand-computed spot values plus a
// direct-formula address model, and hand sequences for row gating, backpressure and reset abort.
module tb_padded_window_addr_gen;
  logic        clk = 1'b0;
  logic        rst, start, padding, stride, line_ready, rd_ready;
  logic [31:0] base_addr;
  logic [7:0]  IFM_C, IFM_W;
  logic        rd_en, last_tap, last_pixel, busy, done;
  logic [31:0] rd_addr;
  logic [3:0]  tap_idx;

  always #5 clk = ~clk;

  padded_window_addr_gen #(.PE(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .IFM_C(IFM_C),
    .IFM_W(IFM_W), .padding(padding), .stride(stride), .line_ready(line_ready),
    .rd_ready(rd_ready), .rd_en(rd_en), .rd_addr(rd_addr), .tap_idx(tap_idx),
    .last_tap(last_tap), .last_pixel(last_pixel), .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          c;
    int          w;
    bit          pad;
    bit          s;
    logic [31:0] base;
    int          nreads;   // total reads expected
    int          ia;       // 1-based read index of spot check A (0 = none)
    logic [31:0] aa;
    int          ib;
    logic [31:0] ab;
    int          flt;      // 1-based index of the first read carrying last_tap
  } vec_t;

  vec_t vecs[7];

  task automatic run_frame(input vec_t v, input bit rnd, input bit poke);
    logic [31:0] exp_a[$];
    logic [3:0]  exp_t[$];
    bit          exp_lt[$];
    bit          exp_lp[$];
    int wp, cwn, ho, s, k, last_acc;
    bit prev_stall, seen_done, seen_lt;
    logic [31:0] prev_addr;
    logic [3:0]  prev_tap;

    wp  = v.w + (v.pad ? 2 : 0);
    cwn = v.c >> 4;
    s   = v.s ? 2 : 1;
    ho  = (wp >= 3 && cwn > 0) ? ((wp - 3) / s) + 1 : 0;
    for (int oy = 0; oy < ho; oy++)
      for (int ox = 0; ox < ho; ox++)
        for (int cw = 0; cw < cwn; cw++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
              int r, cc;
              bit lt;
              r  = oy * s + ky;
              cc = ox * s + kx;
              lt = (ky == 2 && kx == 2 && cw == cwn - 1);
              exp_a.push_back(v.base + 32'(4 * ((r * wp + cc) * cwn + cw)));
              exp_t.push_back(4'(ky * 3 + kx));
              exp_lt.push_back(lt);
              exp_lp.push_back(lt && ox == ho - 1 && oy == ho - 1);
            end

    @(negedge clk);
    IFM_C = 8'(v.c); IFM_W = 8'(v.w); padding = v.pad; stride = v.s;
    base_addr = v.base; start = 1'b1; line_ready = 1'b1; rd_ready = 1'b0;
    k = 0; last_acc = -10; prev_stall = 0; seen_done = 0; seen_lt = 0;
    prev_addr = '0; prev_tap = '0;

    for (int cyc = 1; cyc <= 3000 && !seen_done; cyc++) begin
      @(negedge clk);
      start = (poke && cyc == 20);
      if (poke && cyc == 20) IFM_W = 8'd7;   // config change while busy must be ignored
      line_ready = (cyc < wp);
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (prev_stall) begin
        check("stall_hold_en", rd_en, 1);
        check("stall_hold_addr", rd_addr, prev_addr);
        check("stall_hold_tap", tap_idx, prev_tap);
      end
      if (done) begin
        seen_done = 1;
        check("read_count", k, v.nreads);
        if (v.nreads > 0) check("done_after_last_read", cyc, last_acc + 1);
        else              check("invalid_done_latency", cyc, 2);
      end
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = 0;
      if (rd_en) begin
        if (k < exp_a.size()) begin
          check("addr", rd_addr, exp_a[k]);
          check("tap", tap_idx, exp_t[k]);
          check("last_tap", last_tap, exp_lt[k]);
          check("last_pixel", last_pixel, exp_lp[k]);
          if (k + 1 == v.ia) check("spot_a_addr", rd_addr, v.aa);
          if (k + 1 == v.ib) check("spot_b_addr", rd_addr, v.ab);
          if (k + 1 == v.nreads) check("last_pixel_on_final", last_pixel, 1);
          if (last_tap && !seen_lt) begin
            seen_lt = 1;
            check("first_last_tap_index", k + 1, v.flt);
          end
        end else begin
          check("extra_read", k + 1, exp_a.size());
        end
        if (rd_ready) begin
          k++;
          last_acc = cyc;
        end else begin
          prev_stall = 1;
          prev_addr  = rd_addr;
          prev_tap   = tap_idx;
        end
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    start = 1'b0; line_ready = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    check("done_is_pulse", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{c:16, w:4, pad:1, s:0, base:32'h100,      nreads:144, ia:10, aa:32'h104,      ib:37, ab:32'h118,      flt:9};
    vecs[1] = '{c:16, w:4, pad:1, s:1, base:32'h200,      nreads:36,  ia:10, aa:32'h208,      ib:19, ab:32'h230,      flt:9};
    vecs[2] = '{c:32, w:4, pad:0, s:0, base:32'h1000,     nreads:72,  ia:10, aa:32'h1004,     ib:4,  ab:32'h1020,     flt:18};
    vecs[3] = '{c:0,  w:4, pad:1, s:0, base:32'h100,      nreads:0,   ia:0,  aa:32'h0,        ib:0,  ab:32'h0,        flt:0};
    vecs[4] = '{c:16, w:1, pad:1, s:0, base:32'h40,       nreads:9,   ia:4,  aa:32'h4C,       ib:9,  ab:32'h60,       flt:9};
    vecs[5] = '{c:16, w:4, pad:0, s:0, base:32'hFFFFFFF0, nreads:36,  ia:2,  aa:32'hFFFFFFF4, ib:4,  ab:32'h0,        flt:9};
    vecs[6] = '{c:16, w:1, pad:0, s:0, base:32'h100,      nreads:0,   ia:0,  aa:32'h0,        ib:0,  ab:32'h0,        flt:0};

    rst = 1'b1; start = 1'b0; padding = 1'b0; stride = 1'b0; line_ready = 1'b0;
    rd_ready = 1'b0; base_addr = '0; IFM_C = '0; IFM_W = '0;
    repeat (3) @(negedge clk);
    check("reset_rd_en", rd_en, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_tap", tap_idx, 0);
    check("reset_last_tap", last_tap, 0);
    check("reset_last_pixel", last_pixel, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_frame(vecs[i], 1'b0, 1'b0);

    // Random backpressure plus an ignored start mid-frame.
    run_frame(vecs[0], 1'b1, 1'b1);

    // Row gating: two committed rows are not enough for a 3-row window.
    @(negedge clk);
    IFM_C = 8'd16; IFM_W = 8'd4; padding = 1'b1; stride = 1'b0; base_addr = 32'h100;
    start = 1'b1; line_ready = 1'b0; rd_ready = 1'b1;
    @(negedge clk); start = 1'b0; line_ready = 1'b1;
    @(negedge clk); line_ready = 1'b1;
    @(negedge clk); line_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_en) cnt++;
    end
    check("gated_two_rows", cnt, 0);
    line_ready = 1'b1;
    @(negedge clk); line_ready = 1'b0;
    check("gate_wait_cycle", rd_en, 0);
    @(negedge clk);
    check("gate_first_en", rd_en, 1);
    check("gate_first_addr", rd_addr, 32'h100);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (rd_en) cnt++;
      @(negedge clk);
    end
    check("gate_oy0_reads", cnt, 36);
    check("gate_oy1_stalled", rd_en, 0);
    line_ready = 1'b1;
    @(negedge clk); line_ready = 1'b0;
    check("gate_oy1_wait_cycle", rd_en, 0);
    @(negedge clk);
    check("gate_oy1_en", rd_en, 1);
    check("gate_oy1_addr", rd_addr, 32'h118);
    check("gate_oy1_tap", tap_idx, 0);

    // Abort mid-frame.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rd_ready = 1'b0;
    check("abort_rd_en", rd_en, 0);
    check("abort_rd_addr", rd_addr, 0);
    check("abort_tap", tap_idx, 0);
    check("abort_flags", {last_tap, last_pixel}, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || rd_en) cnt++;
    end
    check("abort_quiet", cnt, 0);

    run_frame(vecs[2], 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
